// File: rtl/noc_out_arbiter.sv
// -----------------------------------------------------------------------------
// noc_out_arbiter
//
// Round-robin output arbiter for one router output. It drains up to NUM_IN
// input FIFOs into a single downstream FIFO through a one-entry output stage.
// The winning flit is registered and presented on out_item in the following
// cycle. The stage reloads in the same cycle it drains, so one flit per cycle
// is sustained while the downstream FIFO has room.
//
// Flit width W = `HDR_SZ + `PL_SZ + `ADDR_SZ (global macros; defaults below
// apply only when the surrounding build does not define them).
//
// Parameters:
//   NUM_IN     number of input FIFOs, 2..8 (default 5: N, E, S, W, local)
//   CNT_W      width of each grant counter (stats build only)
//
// Ports:
//   clk        single clock, rising-edge
//   reset      synchronous, active-high
//   in_empty   [NUM_IN]    empty flags of the input FIFOs
//   in_item    [NUM_IN*W]  head flits of the input FIFOs, input i at [i*W +: W]
//   in_read    [NUM_IN]    pop strobes to the input FIFOs (at most one high)
//   out_full   downstream FIFO full flag
//   out_write  downstream FIFO push strobe
//   out_item   [W]         flit presented to the downstream FIFO
//   grant_cnt  [NUM_IN*CNT_W] saturating per-input grant counters
//              (present only when NOC_OUT_ARB_STATS_EN is defined)
//
// Optional feature macro: NOC_OUT_ARB_STATS_EN
// -----------------------------------------------------------------------------

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module noc_out_arbiter #(
    parameter int NUM_IN = 5,
    parameter int CNT_W  = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_IN-1:0]                             in_empty,
    input  logic [NUM_IN*(`HDR_SZ+`PL_SZ+`ADDR_SZ)-1:0]   in_item,
    output logic [NUM_IN-1:0]                             in_read,
    input  logic                                          out_full,
    output logic                                          out_write,
    output logic [(`HDR_SZ+`PL_SZ+`ADDR_SZ)-1:0]          out_item
`ifdef NOC_OUT_ARB_STATS_EN
    ,
    output logic [NUM_IN*CNT_W-1:0]                       grant_cnt
`endif
);

    localparam int W      = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int PRIO_W = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > 8 || CNT_W < 1) begin : g_param_check
        $error("noc_out_arbiter: NUM_IN must be 2..8 and CNT_W >= 1");
    end

    // Control state
    logic [PRIO_W-1:0] prio;
    logic              vld_p1;

    // Output-stage data
    logic [W-1:0]      hold_item_p1;

    // Combinational arbitration terms
    logic [NUM_IN-1:0] req;
    logic              drain;
    logic              space;
    logic              any_req;
    logic              load;
    logic [PRIO_W-1:0] g;
    logic [PRIO_W-1:0] prio_nxt;

`ifdef NOC_OUT_ARB_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
`endif

    assign req     = ~in_empty;
    assign any_req = |req;
    assign drain   = vld_p1 & ~out_full;
    assign space   = ~vld_p1 | drain;
    assign load    = space & any_req;

    // Round-robin scan: first requester at or after prio, wrapping modulo NUM_IN.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(prio) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                g     = PRIO_W'(idx);
            end
        end
    end

    // Pointer moves to the input just past the winner; input NUM_IN-1 wraps to 0.
    always_comb begin
        if (g == PRIO_W'(NUM_IN - 1)) begin
            prio_nxt = '0;
        end else begin
            prio_nxt = g + PRIO_W'(1);
        end
    end

    // Strobes are forced low during reset so no FIFO is popped or pushed in the
    // reset cycle, even though the output stage still holds its old contents.
    always_comb begin
        in_read = '0;
        if (load && !reset) begin
            in_read[g] = 1'b1;
        end
    end

    assign out_write = drain & ~reset;
    assign out_item  = hold_item_p1;

    // ---- stage p0 -> p1: winning flit captured into the output stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            prio         <= '0;
            vld_p1       <= 1'b0;
            hold_item_p1 <= '0;
        end else if (load) begin
            prio         <= prio_nxt;
            vld_p1       <= 1'b1;
            hold_item_p1 <= in_item[int'(g)*W +: W];
        end else if (drain) begin
            vld_p1       <= 1'b0;
        end
    end

`ifdef NOC_OUT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_IN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (load) begin
            cnt_q[g] <= sat_inc(cnt_q[g]);
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_out_arbiter
//
// Self-checking bench for noc_out_arbiter. Input FIFOs are modelled as queues;
// a reference model of the arbiter (round-robin pointer, one-entry output
// stage, optional saturating grant counters) predicts in_read, out_write,
// out_item and grant_cnt every cycle. Directed scenarios are followed by a
// randomized phase with random arrivals, backpressure and reset pulses.
// Stats build: define NOC_OUT_ARB_STATS_EN for both files.
// -----------------------------------------------------------------------------

`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module tb_noc_out_arbiter;

    localparam int NUM_IN = 5;
    localparam int CNT_W  = 4;
    localparam int W      = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_IN-1:0]     in_empty;
    logic [NUM_IN*W-1:0]   in_item;
    logic [NUM_IN-1:0]     in_read;
    logic                  out_full;
    logic                  out_write;
    logic [W-1:0]          out_item;
`ifdef NOC_OUT_ARB_STATS_EN
    logic [NUM_IN*CNT_W-1:0] grant_cnt;
`endif

    noc_out_arbiter #(
        .NUM_IN (NUM_IN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_item   (in_item),
        .in_read   (in_read),
        .out_full  (out_full),
        .out_write (out_write),
        .out_item  (out_item)
`ifdef NOC_OUT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Input FIFO contents (head at index 0)
    logic [W-1:0] fq [NUM_IN][$];

    // Reference model state
    int           mprio;
    bit           mvld;
    logic [W-1:0] mitem;
    int           mcnt [NUM_IN];

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mprio = 0;
        mvld  = 1'b0;
        mitem = '0;
        for (int i = 0; i < NUM_IN; i++) mcnt[i] = 0;
    endtask

    // One clock cycle: drive FIFO heads, check outputs mid-cycle, advance model.
    task automatic step();
        logic [NUM_IN-1:0] er;
        bit                found, drain, space, load;
        int                g;
        logic [W-1:0]      popped;

        for (int i = 0; i < NUM_IN; i++) begin
            in_empty[i] = (fq[i].size() == 0);
            in_item[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : W'(32'h5A5A ^ i);
        end

        @(negedge clk);
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            int i;
            i = (mprio + k) % NUM_IN;
            if (!found && fq[i].size() != 0) begin
                found = 1'b1;
                g     = i;
            end
        end
        drain = mvld && !out_full;
        space = !mvld || drain;
        load  = space && found;
        er    = '0;
        if (load && !reset) er[g] = 1'b1;

        chk("in_read",   64'(in_read),   64'(er));
        chk("out_write", 64'(out_write), 64'(drain && !reset));
        chk("out_item",  64'(out_item),  64'(mitem));
`ifdef NOC_OUT_ARB_STATS_EN
        for (int i = 0; i < NUM_IN; i++)
            chk($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i*CNT_W +: CNT_W]), 64'(mcnt[i]));
`endif
        if (out_write) n_wr++;

        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else if (load) begin
            popped = fq[g].pop_front();
            mitem  = popped;
            mvld   = 1'b1;
            mprio  = (g + 1) % NUM_IN;
            if (mcnt[g] < CMAX) mcnt[g]++;
        end else if (drain) begin
            mvld = 1'b0;
        end
    endtask

    task automatic flush_fifos();
        for (int i = 0; i < NUM_IN; i++) fq[i].delete();
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        flush_fifos();
    endtask

    initial begin
        reset    = 1'b1;
        out_full = 1'b0;
        in_empty = '1;
        in_item  = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, then idle inputs for 20 cycles
        reset_cycle();
        repeat (20) step();

        // Only input 2 has data
        fq[2].push_back(W'('hA1));
        fq[2].push_back(W'('hA2));
        fq[2].push_back(W'('hA3));
        n_wr = 0;
        repeat (6) step();
        chk("single_in_writes", 64'(n_wr), 64'd3);

        // All inputs continuously requesting: strict rotation from input 0
        reset_cycle();
        for (int i = 0; i < NUM_IN; i++)
            for (int j = 0; j < 8; j++) fq[i].push_back(W'((i << 4) | j));
        repeat (7) step();
        chk("rotation_prio", 64'(mprio), 64'd2);

        // Backpressure on a held flit
        reset_cycle();
        fq[0].push_back(W'('hB7));
        fq[3].push_back(W'('hC1));
        step();
        out_full = 1'b1;
        repeat (4) step();
        out_full = 1'b0;
        n_wr = 0;
        repeat (3) step();
        chk("bp_writes", 64'(n_wr), 64'd2);

        // Reset while the output stage holds a flit
        reset_cycle();
        for (int i = 0; i < NUM_IN; i++)
            for (int j = 0; j < 4; j++) fq[i].push_back(W'(8'hE0 | (i << 2) | j));
        repeat (3) step();
        out_full = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        out_full = 1'b0;
        repeat (4) step();

`ifdef NOC_OUT_ARB_STATS_EN
        // Counter saturation on input 1
        reset_cycle();
        for (int j = 0; j < 20; j++) fq[1].push_back(W'(j));
        repeat (24) step();
        chk("cnt_sat_in1", 64'(grant_cnt[1*CNT_W +: CNT_W]), 64'(CMAX));
        chk("cnt_in0", 64'(grant_cnt[0 +: CNT_W]), 64'd0);
`endif

        // Randomized traffic, backpressure and occasional reset
        reset_cycle();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_IN; i++)
                if (fq[i].size() < 4 && $urandom_range(0, 2) == 0)
                    fq[i].push_back(W'($urandom));
            out_full = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            step();
            reset    = 1'b0;
        end
        out_full = 1'b0;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
